pll_serial_loader: RTL and testbench
====================================

PLL_SERIAL_LOADER -- requirements
Module: pll_serial_loader

Interface
REQ-001 Parameter NUM_REGS, default 10: number of configuration words.
REQ-002 Parameter REG_W, default 32: bits per word.
REQ-003 Parameter DIV, default 1: sclk half-period in clk cycles; SHALL be >=1.
REQ-004 Parameter LE_HOLD, default 2: clk cycles le is held high between words; SHALL be >=1.
REQ-005 clk  in  1  system clock.
REQ-006 srst_n  in  1  reset, synchronous, active-low.
REQ-007 reg_wr  in  1  write strobe for the register file.
REQ-008 reg_addr  in  clog2(NUM_REGS)  word index.
REQ-009 reg_wdata  in  REG_W  word value.
REQ-010 start  in  1  begin a programming sequence.
REQ-011 abort  in  1  stop the sequence and deactivate.
REQ-012 muxout  in  1  device MUXOUT pin, asynchronous.
REQ-013 busy  out  1  programming sequence in progress.
REQ-014 done  out  1  one-cycle pulse when the sequence completes.
REQ-015 active  out  1  device programmed and running.
REQ-016 sclk, sdata, le, ce  out  1 each  device serial clock, data, load-enable and chip-enable pins.
REQ-017 ramp_start  out  1  one-cycle pulse at ramp start.

Function
REQ-018 Register file writes SHALL complete in one cycle while busy=0; writes SHALL be ignored while busy=1, and addresses >= NUM_REGS SHALL be ignored.
REQ-019 The FSM SHALL have the states IDLE, SHIFT, LATCH and ACTIVE.
REQ-020 A start in IDLE or ACTIVE SHALL move the FSM to SHIFT with word index NUM_REGS-1; start SHALL be ignored in SHIFT and LATCH.
REQ-021 SHIFT SHALL hold le=0 and send the word MSB first; sdata SHALL change only while sclk=0; each bit SHALL take 2*DIV cycles (DIV cycles low, then DIV cycles high).
REQ-022 After the last bit the FSM SHALL enter LATCH with le=1, sclk=0 and sdata=0 for LE_HOLD cycles, then decrement the index and return to SHIFT, or go to ACTIVE after index 0.
REQ-023 Words SHALL be sent in descending index order, NUM_REGS-1 down to 0.
REQ-024 busy SHALL be 1 exactly in SHIFT and LATCH.
REQ-025 done SHALL pulse on the cycle ACTIVE is entered; active SHALL be 1 only in ACTIVE.
REQ-026 With start seen in cycle 0, le SHALL fall in cycle 1 and done SHALL assert in cycle NUM_REGS*(2*DIV*REG_W+LE_HOLD)+1.
REQ-027 A start in ACTIVE SHALL reprogram all words; active SHALL drop to 0 until the new done.
REQ-028 abort in any state SHALL force IDLE the next cycle with le=1, sclk=0, sdata=0, busy=0 and active=0, and SHALL take priority over a simultaneous start.
REQ-029 The word index and bit counters SHALL never wrap below 0; REG_W=1 and NUM_REGS=1 SHALL be supported.

Reset
REQ-030 While srst_n=0: state=IDLE, le=1, sclk=0, sdata=0, ce=0, busy=0, done=0, active=0, ramp_start=0, sync flops=0; register file contents SHALL be preserved.
REQ-031 ce SHALL be 1 from the first cycle after reset release.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence and SHALL produce no done pulse.

Configuration
REQ-033 Macro PLL_SERIAL_LOADER_RAMP_DET_EN, when defined: muxout SHALL pass through a 2-flop synchroniser, and ramp_start SHALL pulse one cycle on each falling edge of the synchronised muxout while active=1.
REQ-034 Without PLL_SERIAL_LOADER_RAMP_DET_EN: ramp_start SHALL be constant 0, muxout SHALL be unused, and no synchroniser SHALL be instantiated.

Structure
REQ-035 Package pll_loader_pkg SHALL hold the state encoding and the default parameter constants.
REQ-036 The muxout synchroniser SHALL be an instance of the existing ff_sync (WIDTH=1, STAGES=2); there SHALL be no other sub-module.

Verification (NUM_REGS=3, REG_W=8, DIV=1, LE_HOLD=2)
REQ-037 Write 0xA5, 0x3C, 0x81 to indices 0-2, then start -> sdata sampled on sclk rising edges reads 0x81, 0x3C, 0xA5; le high for 2 cycles between words; done in cycle 55.
REQ-038 Write 0xFF to index 1 while busy -> ignored; the next sequence still sends 0x3C.
REQ-039 abort during bit 4 of the second word -> the next cycle shows le=1, sclk=0, busy=0, with no done pulse.
REQ-040 start while active -> active falls, a full 3-word resend follows, and done pulses again at +55 cycles.
REQ-041 With the macro defined and active=1, muxout falling -> exactly one ramp_start pulse 3 cycles later; no pulse while active=0.
REQ-042 srst_n=0 mid-shift -> all outputs at reset values and register contents intact on the following start.

Source files
------------

// File: rtl/pll_loader_pkg.sv
// Shared types and defaults for the PLL serial loader: FSM encoding,
// default parameter values and a width helper.
package pll_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_LATCH  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam int DEF_NUM_REGS = 10;
  localparam int DEF_REG_W    = 32;
  localparam int DEF_DIV      = 1;
  localparam int DEF_LE_HOLD  = 2;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ff_sync.sv
// Multi-stage flop synchroniser for asynchronous inputs, synchronous
// active-low reset clears every stage.
module ff_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/pll_serial_loader.sv
// Serial programmer for a PLL synthesiser: shifts NUM_REGS words MSB first,
// highest index first. Define PLL_SERIAL_LOADER_RAMP_DET_EN for ramp detection.
module pll_serial_loader
  import pll_loader_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_W    = DEF_REG_W,
  parameter int DIV      = DEF_DIV,
  parameter int LE_HOLD  = DEF_LE_HOLD
) (
  input  logic                          clk,
  input  logic                          srst_n,
  input  logic                          reg_wr,
  input  logic [width_of(NUM_REGS)-1:0] reg_addr,
  input  logic [REG_W-1:0]              reg_wdata,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          muxout,
  output logic                          busy,
  output logic                          done,
  output logic                          active,
  output logic                          sclk,
  output logic                          sdata,
  output logic                          le,
  output logic                          ce,
  output logic                          ramp_start
);

  localparam int ADDR_W = width_of(NUM_REGS);
  localparam int BIT_W  = width_of(REG_W);
  localparam int CNT_W  = width_of((DIV > LE_HOLD) ? DIV : LE_HOLD);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_REGS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(REG_W - 1);
  localparam logic [CNT_W-1:0]  DIV_END   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  HOLD_END  = CNT_W'(LE_HOLD - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sclk_q, sclk_d;
  logic              done_q, done_d;
  logic              ce_q, ce_d;

  // Register file has no reset so contents survive srst_n.
  logic [REG_W-1:0] regs_q [NUM_REGS];
  logic [REG_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (reg_wr && !busy && (int'(reg_addr) < NUM_REGS)) begin
      regs_d[reg_addr] = reg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    sclk_d     = sclk_q;
    done_d     = 1'b0;
    ce_d       = 1'b1;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          word_idx_d = LAST_WORD;
          bit_idx_d  = LAST_BIT;
          cnt_d      = '0;
          sclk_d     = 1'b0;
        end
      end
      ST_SHIFT: begin
        // Each bit: DIV cycles low (data may move), then DIV cycles high.
        if (cnt_q == DIV_END) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_idx_q == '0) begin
              state_d = ST_LATCH;
            end else begin
              bit_idx_d = bit_idx_q - BIT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (cnt_q == HOLD_END) begin
          cnt_d = '0;
          if (word_idx_q == '0) begin
            state_d = ST_ACTIVE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_SHIFT;
            word_idx_d = word_idx_q - ADDR_W'(1);
            bit_idx_d  = LAST_BIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      sclk_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      sclk_q     <= 1'b0;
      done_q     <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      sclk_q     <= sclk_d;
      done_q     <= done_d;
      ce_q       <= ce_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT) || (state_q == ST_LATCH);
  assign active = (state_q == ST_ACTIVE);
  assign done   = done_q;
  assign ce     = ce_q;
  assign le     = (state_q != ST_SHIFT);
  assign sclk   = (state_q == ST_SHIFT) && sclk_q;
  assign sdata  = (state_q == ST_SHIFT) ? regs_q[word_idx_q][bit_idx_q] : 1'b0;

`ifdef PLL_SERIAL_LOADER_RAMP_DET_EN
  logic mux_s;
  logic mux_prev_q, mux_prev_d;
  logic ramp_q, ramp_d;

  ff_sync #(.WIDTH(1), .STAGES(2)) u_mux_sync (
    .clk    (clk),
    .srst_n (srst_n),
    .d      (muxout),
    .q      (mux_s)
  );

  always_comb begin
    mux_prev_d = mux_s;
    ramp_d     = active && mux_prev_q && !mux_s;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      mux_prev_q <= 1'b0;
      ramp_q     <= 1'b0;
    end else begin
      mux_prev_q <= mux_prev_d;
      ramp_q     <= ramp_d;
    end
  end

  assign ramp_start = ramp_q;
`else
  logic unused_muxout;
  assign unused_muxout = muxout;
  assign ramp_start    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_serial_loader.sv
// Bench for pll_serial_loader with NUM_REGS=3, REG_W=8, DIV=1, LE_HOLD=2.
// Define PLL_SERIAL_LOADER_RAMP_DET_EN to also exercise ramp detection.
module tb_pll_serial_loader;

  localparam int NUM_REGS = 3;
  localparam int REG_W    = 8;
  localparam int DIV      = 1;
  localparam int LE_HOLD  = 2;
  localparam int SEQ_CYC  = NUM_REGS * (2 * DIV * REG_W + LE_HOLD) + 1;

  logic             clk = 1'b0;
  logic             srst_n, reg_wr, start, abort, muxout;
  logic [1:0]       reg_addr;
  logic [REG_W-1:0] reg_wdata;
  logic             busy, done, active, sclk, sdata, le, ce, ramp_start;

  int n_checks = 0;
  int n_fail   = 0;

  logic [REG_W-1:0] model_regs [NUM_REGS];
  logic [REG_W-1:0] exp_q[$];

  typedef struct {
    logic [REG_W-1:0] wr  [NUM_REGS];
    logic [REG_W-1:0] exp [NUM_REGS];
  } vec_t;
  vec_t vecs [3];

  pll_serial_loader #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .DIV      (DIV),
    .LE_HOLD  (LE_HOLD)
  ) dut (
    .clk        (clk),
    .srst_n     (srst_n),
    .reg_wr     (reg_wr),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .start      (start),
    .abort      (abort),
    .muxout     (muxout),
    .busy       (busy),
    .done       (done),
    .active     (active),
    .sclk       (sclk),
    .sdata      (sdata),
    .le         (le),
    .ce         (ce),
    .ramp_start (ramp_start)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_idle_pins(input string tag, input logic exp_ce);
    check({tag, "_le"}, le, 1'b1);
    check({tag, "_sclk"}, sclk, 1'b0);
    check({tag, "_sdata"}, sdata, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_active"}, active, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_ce"}, ce, exp_ce);
    check({tag, "_ramp"}, ramp_start, 1'b0);
  endtask

  // Drivers
  task automatic write_reg(input logic [1:0] a, input logic [REG_W-1:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 1'b0;
    if (int'(a) < NUM_REGS) model_regs[a] = d;
  endtask

  task automatic load_from_model();
    exp_q.delete();
    for (int i = NUM_REGS - 1; i >= 0; i--) exp_q.push_back(model_regs[i]);
  endtask

  // Runs one full sequence, decoding the serial stream against exp_q.
  // A write is attempted at cycle wr_at (ignored by the device since busy).
  task automatic run_seq(input string tag, input int wr_at, input logic [1:0] wr_a,
                         input logic [REG_W-1:0] wr_d);
    int cyc, done_cyc, nbits, le_run, edge_bad, ramp_bad;
    logic prev_sclk, prev_sdata;
    logic [REG_W-1:0] sh;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; done_cyc = -1; nbits = 0; le_run = 0; edge_bad = 0; ramp_bad = 0;
    sh = '0; prev_sclk = 1'b0; prev_sdata = sdata;
    check({tag, "_le_fall"}, le, 1'b0);
    check({tag, "_active_drop"}, active, 1'b0);
    check({tag, "_busy_rise"}, busy, 1'b1);
    while (cyc <= SEQ_CYC + 20 && done_cyc < 0) begin
      if (sclk && !prev_sclk) begin
        sh = {sh[REG_W-2:0], sdata};
        nbits++;
        if (nbits == REG_W) begin
          nbits = 0;
          if (exp_q.size() > 0) check({tag, "_word"}, sh, exp_q.pop_front());
          else check({tag, "_extra_word"}, 1, 0);
        end
      end
      if (sclk && (sdata !== prev_sdata)) edge_bad++;
      if (ramp_start !== 1'b0) ramp_bad++;
      if (le && busy) le_run++;
      else if (!le && le_run > 0) begin
        check({tag, "_le_hold"}, le_run, LE_HOLD);
        le_run = 0;
      end
      if (done) begin
        done_cyc = cyc;
        check({tag, "_le_hold_last"}, le_run, LE_HOLD);
        check({tag, "_active_at_done"}, active, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
      end
      prev_sclk = sclk; prev_sdata = sdata;
      if (done_cyc < 0) begin
        if (cyc == wr_at) begin
          reg_wr = 1'b1; reg_addr = wr_a; reg_wdata = wr_d;
        end
        tick();
        reg_wr = 1'b0;
        cyc++;
      end
    end
    check({tag, "_done_cycle"}, done_cyc, SEQ_CYC);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_sdata_moved_sclk_high"}, edge_bad, 0);
    check({tag, "_ramp_quiet"}, ramp_bad, 0);
    tick();
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_active_hold"}, active, 1'b1);
  endtask

  // Stimulus and scoreboard
  initial begin
    int dn, bz, pulses, first;
    srst_n = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
    start = 1'b0; abort = 1'b0; muxout = 1'b1;
    repeat (3) tick();
    check_idle_pins("reset", 1'b0);
    srst_n = 1'b1;
    tick();
    check_idle_pins("post_reset", 1'b1);

    vecs[0].wr = '{8'hA5, 8'h3C, 8'h81}; vecs[0].exp = '{8'h81, 8'h3C, 8'hA5};
    vecs[1].wr = '{8'h00, 8'hFF, 8'h55}; vecs[1].exp = '{8'h55, 8'hFF, 8'h00};
    vecs[2].wr = '{8'h01, 8'h80, 8'h7E}; vecs[2].exp = '{8'h7E, 8'h80, 8'h01};
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < NUM_REGS; i++) write_reg(2'(i), vecs[v].wr[i]);
      exp_q.delete();
      for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(vecs[v].exp[i]);
      run_seq($sformatf("vec%0d", v), -1, 2'd0, '0);
    end

    // Busy write ignored, out-of-range write ignored, restart from ACTIVE.
    for (int i = 0; i < NUM_REGS; i++) write_reg(2'(i), vecs[0].wr[i]);
    write_reg(2'd3, 8'h77);
    load_from_model();
    run_seq("busy_wr", 5, 2'd1, 8'hFF);
    load_from_model();
    check("model_idx1", model_regs[1], 8'h3C);
    run_seq("after_busy_wr", -1, 2'd0, '0);

    // Abort mid second word, then abort against a simultaneous start.
    start = 1'b1; tick(); start = 1'b0;
    repeat (24) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle_pins("abort", 1'b1);
    dn = 0; bz = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (done) dn++;
      if (busy) bz++;
    end
    check("abort_no_done", dn, 0);
    check("abort_stays_idle", bz, 0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("abort_beats_start_busy", busy, 1'b0);
    check("abort_beats_start_le", le, 1'b1);

    // Reset mid-shift keeps register contents.
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    srst_n = 1'b0; tick();
    check_idle_pins("mid_reset", 1'b0);
    tick();
    srst_n = 1'b1; tick();
    check("mid_reset_ce", ce, 1'b1);
    check("mid_reset_no_done", done, 1'b0);
    load_from_model();
    run_seq("after_reset", -1, 2'd0, '0);

    // Randomised programs against the model.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_REGS; i++) write_reg(2'(i), REG_W'($urandom));
      if ($urandom_range(0, 1) == 1) write_reg(2'd3, REG_W'($urandom));
      load_from_model();
      run_seq($sformatf("rand%0d", r), $urandom_range(2, 50),
              2'($urandom_range(0, 2)), REG_W'($urandom));
    end

`ifdef PLL_SERIAL_LOADER_RAMP_DET_EN
    repeat (4) tick();
    muxout = 1'b0;
    pulses = 0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ramp_start) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("ramp_latency", first, 3);
    check("ramp_pulses", pulses, 1);
    muxout = 1'b1;
    repeat (4) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    muxout = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ramp_start) pulses++;
    end
    check("ramp_inactive", pulses, 0);
    muxout = 1'b1;
`else
    pulses = 0; first = 0;
    muxout = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ramp_start) pulses++;
    end
    check("ramp_disabled", pulses + first, 0);
    muxout = 1'b1;
`endif

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
